msf_frame_encoder: RTL

//  Transmit side of the MSF time-code link: turns a 60-second frame of A/B bits into the

---
 rtl/msf_frame_encoder_if.sv | 11 +
 rtl/msf_frame_encoder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/msf_frame_encoder_if.sv
// Frame-load channel of the MSF encoder: one 60-bit A/B frame per valid/ready handshake.
// A transfer happens on a clk edge where load_valid_i && load_ready_o; valid is ignored while ready is low.
interface msf_frame_encoder_if;
    logic [59:0] a_bits_i;
    logic [59:0] b_bits_i;
    logic        load_valid_i;
    logic        load_ready_o;

    modport master (output a_bits_i, output b_bits_i, output load_valid_i, input load_ready_o);
    modport slave  (input a_bits_i, input b_bits_i, input load_valid_i, output load_ready_o);
endinterface

// File: rtl/msf_frame_encoder.sv
// MSF time-code transmitter: double-buffered 60 s A/B frame to a carrier-off waveform.
// Optional build macro MSF_ENC_PARITY_EN replaces B[54..57] with odd parity over the A-bit groups.
module msf_frame_encoder #(
    parameter int CLK_PER_SLOT = 100
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    msf_frame_encoder_if.slave  load,
    output logic                data_o,
    output logic [5:0]          second_o,
    output logic [3:0]          slot_o,
    output logic                frame_start_o,
    output logic                underrun_o,
    output logic                state_o
);
    localparam int TW = (CLK_PER_SLOT > 1) ? $clog2(CLK_PER_SLOT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_SLOT - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [59:0]   shadow_a, shadow_b;
    logic [59:0]   active_a, active_b;
    logic          shadow_full;
    logic          load_fire;
    logic          tick_wrap, slot_wrap, frame_wrap;
    logic [TW-1:0] tick_nxt;
    logic [3:0]    slot_nxt;
    logic [5:0]    sec_nxt;
    logic          data_nxt;
    logic [59:0]   xfer_b;

    assign load.load_ready_o = !shadow_full;
    assign load_fire         = load.load_valid_i && !shadow_full;
    assign state_o           = (state == S_RUN);

`ifdef MSF_ENC_PARITY_EN
    // Parity bit makes the group plus itself carry an odd number of ones.
    always_comb begin
        xfer_b     = shadow_b;
        xfer_b[54] = ~^shadow_a[24:17];
        xfer_b[55] = ~^shadow_a[35:25];
        xfer_b[56] = ~^shadow_a[38:36];
        xfer_b[57] = ~^shadow_a[51:39];
    end
`else
    assign xfer_b = shadow_b;
`endif

    // Waveform is derived from the next counter values so data_o lines up with second_o/slot_o.
    always_comb begin
        tick_wrap  = (tick == TICK_LAST);
        slot_wrap  = tick_wrap && (slot_o == 4'd9);
        frame_wrap = slot_wrap && (second_o == 6'd59);
        tick_nxt   = tick_wrap ? '0 : tick + TW'(1);
        slot_nxt   = slot_o;
        if (tick_wrap) slot_nxt = slot_wrap ? 4'd0 : slot_o + 4'd1;
        sec_nxt    = second_o;
        if (slot_wrap) sec_nxt = frame_wrap ? 6'd0 : second_o + 6'd1;
        data_nxt   = 1'b0;
        if (sec_nxt == 6'd0) begin
            data_nxt = (slot_nxt < 4'd5);
        end else begin
            case (slot_nxt)
                4'd0:    data_nxt = 1'b1;
                4'd1:    data_nxt = active_a[sec_nxt];
                4'd2:    data_nxt = active_b[sec_nxt];
                default: data_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            tick          <= '0;
            slot_o        <= '0;
            second_o      <= '0;
            data_o        <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            shadow_full   <= 1'b0;
            shadow_a      <= '0;
            shadow_b      <= '0;
            active_a      <= '0;
            active_b      <= '0;
        end else begin
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            // A load can only land while the shadow is empty, so it never collides with a swap.
            if (load_fire) begin
                shadow_a    <= load.a_bits_i;
                shadow_b    <= load.b_bits_i;
                shadow_full <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    data_o <= 1'b0;
                    if (enable_i && shadow_full) begin
                        state         <= S_RUN;
                        active_a      <= shadow_a;
                        active_b      <= xfer_b;
                        shadow_full   <= 1'b0;
                        tick          <= '0;
                        slot_o        <= '0;
                        second_o      <= '0;
                        data_o        <= 1'b1;
                        frame_start_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!enable_i) begin
                        state    <= S_IDLE;
                        data_o   <= 1'b0;
                        tick     <= '0;
                        slot_o   <= '0;
                        second_o <= '0;
                    end else begin
                        tick     <= tick_nxt;
                        slot_o   <= slot_nxt;
                        second_o <= sec_nxt;
                        data_o   <= data_nxt;
                        if (frame_wrap) begin
                            frame_start_o <= 1'b1;
                            if (shadow_full) begin
                                active_a    <= shadow_a;
                                active_b    <= xfer_b;
                                shadow_full <= 1'b0;
                            end else begin
                                underrun_o  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
